// File: rtl/lsq_pipe.sv
// Load/store queue: in-order issue to dcache, CDB snooping, sub-word load extraction.
// Optional misaligned-access trap enabled by defining LSQ_MISALIGN_TRAP_EN.
module lsq_pipe #(
    parameter int DEPTH     = 8,
    parameter int CDB_PORTS = 2,
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int TAG_W     = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        lsm_write,
    input  logic [3:0]                  lsm_op,
    input  logic [TAG_W-1:0]            lsm_rob,
    input  logic [DATA_W-1:0]           lsm_base,
    input  logic [TAG_W-1:0]            lsm_base_lock,
    input  logic [DATA_W-1:0]           lsm_sdata,
    input  logic [TAG_W-1:0]            lsm_sdata_lock,
    input  logic [ADDR_W-1:0]           lsm_offset,
    input  logic [CDB_PORTS*TAG_W-1:0]  cdb_in_index,
    input  logic [CDB_PORTS*DATA_W-1:0] cdb_in_data,
    output logic                        buffer_full,
    input  logic                        rob_stall,
    output logic                        dcache_read,
    output logic [ADDR_W-1:0]           dcache_read_addr,
    input  logic                        dcache_read_done,
    input  logic [DATA_W-1:0]           dcache_read_data,
    output logic                        cdb_out_valid,
    output logic [TAG_W-1:0]            cdb_out_index,
    output logic [DATA_W-1:0]           cdb_out_data,
    output logic [ADDR_W-1:0]           cdb_out_addr,
    output logic                        cdb_out_exc
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] NO_LOCK = '1;
    localparam logic [0:0] S_IDLE      = 1'b0;
    localparam logic [0:0] S_LOAD_WAIT = 1'b1;

    logic              e_v    [DEPTH];
    logic              e_st   [DEPTH];
    logic              e_un   [DEPTH];
    logic [1:0]        e_sz   [DEPTH];
    logic [TAG_W-1:0]  e_rob  [DEPTH];
    logic [DATA_W-1:0] e_base [DEPTH];
    logic [TAG_W-1:0]  e_bl   [DEPTH];
    logic [DATA_W-1:0] e_sd   [DEPTH];
    logic [TAG_W-1:0]  e_sl   [DEPTH];
    logic [ADDR_W-1:0] e_off  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   count;
    logic [0:0]    state;

    logic              h_v;
    logic              h_st;
    logic              h_un;
    logic [1:0]        h_sz;
    logic [TAG_W-1:0]  h_rob;
    logic [DATA_W-1:0] h_sd;
    logic              h_bready;
    logic              h_sready;
    logic [ADDR_W-1:0] h_addr;
    logic [ADDR_W-1:0] al_addr;

    logic push_ok;
    logic load_go;
    logic st_go;
    logic trap_go;
    logic ld_done;
    logic pop;

    // Lowest port wins: the first hit freezes the result.
    function automatic logic [TAG_W+DATA_W-1:0] snoop(
        input logic [TAG_W-1:0]            lk,
        input logic [DATA_W-1:0]           v,
        input logic [CDB_PORTS*TAG_W-1:0]  ib,
        input logic [CDB_PORTS*DATA_W-1:0] db
    );
        logic [TAG_W-1:0]  l;
        logic [DATA_W-1:0] d;
        logic              hit;
        l   = lk;
        d   = v;
        hit = 1'b0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (!hit && lk != NO_LOCK && ib[p*TAG_W +: TAG_W] == lk) begin
                hit = 1'b1;
                l   = NO_LOCK;
                d   = db[p*DATA_W +: DATA_W];
            end
        end
        return {l, d};
    endfunction

    function automatic logic [DATA_W-1:0] extract(
        input logic [DATA_W-1:0] w,
        input logic [1:0]        a,
        input logic [1:0]        sz,
        input logic              uns
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = w[8*a +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   r = {{(DATA_W-8){b[7] & ~uns}}, b};
            2'b01:   r = {{(DATA_W-16){h[15] & ~uns}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    assign buffer_full = (count == (PW+1)'(DEPTH));
    assign push_ok     = lsm_write && !buffer_full && !flush;
    assign dcache_read = (state == S_LOAD_WAIT);

    assign h_v      = e_v[head];
    assign h_st     = e_st[head];
    assign h_un     = e_un[head];
    assign h_sz     = e_sz[head];
    assign h_rob    = e_rob[head];
    assign h_sd     = e_sd[head];
    assign h_bready = (e_bl[head] == NO_LOCK);
    assign h_sready = (e_sl[head] == NO_LOCK);
    assign h_addr   = ADDR_W'(e_base[head]) + e_off[head];

    always_comb begin
        al_addr = h_addr;
        case (h_sz)
            2'b01:   al_addr[0]   = 1'b0;
            2'b10:   al_addr[1:0] = 2'b00;
            default: al_addr      = h_addr;
        endcase
    end

`ifdef LSQ_MISALIGN_TRAP_EN
    logic mis;
    assign mis = (h_sz == 2'b01 && h_addr[0]) ||
                 (h_sz == 2'b10 && h_addr[1:0] != 2'b00);
    // Stores still honour rob_stall even when they trap.
    assign trap_go = (state == S_IDLE) && h_v && h_bready && mis &&
                     (!h_st || !rob_stall);
`else
    assign trap_go = 1'b0;
`endif

    assign load_go = (state == S_IDLE) && h_v && !h_st && h_bready &&
                     !trap_go;
    assign st_go   = (state == S_IDLE) && h_v && h_st && h_bready &&
                     h_sready && !rob_stall && !trap_go;
    assign ld_done = (state == S_LOAD_WAIT) && dcache_read_done;
    assign pop     = st_go || ld_done || trap_go;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_v[i]    <= 1'b0;
                e_st[i]   <= 1'b0;
                e_un[i]   <= 1'b0;
                e_sz[i]   <= 2'b00;
                e_rob[i]  <= '0;
                e_base[i] <= '0;
                e_bl[i]   <= NO_LOCK;
                e_sd[i]   <= '0;
                e_sl[i]   <= NO_LOCK;
                e_off[i]  <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_v[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_v[i]) begin
                    {e_bl[i], e_base[i]} <= snoop(e_bl[i], e_base[i],
                                                  cdb_in_index, cdb_in_data);
                    {e_sl[i], e_sd[i]}   <= snoop(e_sl[i], e_sd[i],
                                                  cdb_in_index, cdb_in_data);
                end
            end
            if (push_ok) begin
                e_v[tail]   <= 1'b1;
                e_st[tail]  <= lsm_op[3];
                e_un[tail]  <= lsm_op[2];
                e_sz[tail]  <= lsm_op[1:0];
                e_rob[tail] <= lsm_rob;
                e_off[tail] <= lsm_offset;
                {e_bl[tail], e_base[tail]} <= snoop(lsm_base_lock, lsm_base,
                                                    cdb_in_index, cdb_in_data);
                {e_sl[tail], e_sd[tail]}   <= snoop(lsm_sdata_lock, lsm_sdata,
                                                    cdb_in_index, cdb_in_data);
                tail <= tail + 1'b1;
            end
            if (pop) begin
                e_v[head] <= 1'b0;
                head      <= head + 1'b1;
            end
            count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            dcache_read_addr <= '0;
        end else if (flush) begin
            state <= S_IDLE;
        end else if (load_go) begin
            state            <= S_LOAD_WAIT;
            dcache_read_addr <= {al_addr[ADDR_W-1:2], 2'b00};
        end else if (ld_done) begin
            state <= S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_out_valid <= 1'b0;
            cdb_out_index <= NO_LOCK;
            cdb_out_data  <= '0;
            cdb_out_addr  <= '0;
        end else begin
            cdb_out_valid <= pop && !flush;
            if (pop) begin
                cdb_out_index <= h_rob;
                if (trap_go) begin
                    cdb_out_data <= '0;
                    cdb_out_addr <= '0;
                end else if (h_st) begin
                    cdb_out_data <= h_sd;
                    cdb_out_addr <= al_addr;
                end else begin
                    cdb_out_data <= extract(dcache_read_data, al_addr[1:0],
                                            h_sz, h_un);
                    cdb_out_addr <= '0;
                end
            end
        end
    end

`ifdef LSQ_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cdb_out_exc <= 1'b0;
        end else if (pop) begin
            cdb_out_exc <= trap_go;
        end
    end
`else
    assign cdb_out_exc = 1'b0;
`endif

endmodule

// File: tb/tb_lsq_pipe.sv
// Directed testbench for lsq_pipe: loads, stores, snooping, full, flush, misalign.
module tb_lsq_pipe;

    localparam int TW = 5;
    localparam logic [TW-1:0] NL = 5'h1F;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        lsm_write;
    logic [3:0]  lsm_op;
    logic [4:0]  lsm_rob;
    logic [31:0] lsm_base;
    logic [4:0]  lsm_base_lock;
    logic [31:0] lsm_sdata;
    logic [4:0]  lsm_sdata_lock;
    logic [31:0] lsm_offset;
    logic [9:0]  cdb_in_index;
    logic [63:0] cdb_in_data;
    logic        buffer_full;
    logic        rob_stall;
    logic        dcache_read;
    logic [31:0] dcache_read_addr;
    logic        dcache_read_done;
    logic [31:0] dcache_read_data;
    logic        cdb_out_valid;
    logic [4:0]  cdb_out_index;
    logic [31:0] cdb_out_data;
    logic [31:0] cdb_out_addr;
    logic        cdb_out_exc;

    int checks = 0;
    int errors = 0;

    lsq_pipe #(
        .DEPTH(8), .CDB_PORTS(2), .DATA_W(32), .ADDR_W(32), .TAG_W(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .lsm_write(lsm_write), .lsm_op(lsm_op), .lsm_rob(lsm_rob),
        .lsm_base(lsm_base), .lsm_base_lock(lsm_base_lock),
        .lsm_sdata(lsm_sdata), .lsm_sdata_lock(lsm_sdata_lock),
        .lsm_offset(lsm_offset),
        .cdb_in_index(cdb_in_index), .cdb_in_data(cdb_in_data),
        .buffer_full(buffer_full), .rob_stall(rob_stall),
        .dcache_read(dcache_read), .dcache_read_addr(dcache_read_addr),
        .dcache_read_done(dcache_read_done),
        .dcache_read_data(dcache_read_data),
        .cdb_out_valid(cdb_out_valid), .cdb_out_index(cdb_out_index),
        .cdb_out_data(cdb_out_data), .cdb_out_addr(cdb_out_addr),
        .cdb_out_exc(cdb_out_exc)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [4:0] rob,
                        input logic [31:0] base, input logic [4:0] bl,
                        input logic [31:0] sd, input logic [4:0] sl,
                        input logic [31:0] off);
        lsm_write      = 1'b1;
        lsm_op         = op;
        lsm_rob        = rob;
        lsm_base       = base;
        lsm_base_lock  = bl;
        lsm_sdata      = sd;
        lsm_sdata_lock = sl;
        lsm_offset     = off;
        tick();
        lsm_write = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (buffer_full !== 1'b0 || dcache_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got full=%b rd=%b exp 0 0",
                     buffer_full, dcache_read);
        end
        checks++;
        if (cdb_out_valid !== 1'b0 || cdb_out_exc !== 1'b0) begin
            errors++;
            $display("FAIL reset_cdb got v=%b exc=%b exp 0 0",
                     cdb_out_valid, cdb_out_exc);
        end
        checks++;
        if (cdb_out_index !== NL || cdb_out_data !== 32'h0 ||
            dcache_read_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_vals got idx=%h data=%h addr=%h exp 1f 0 0",
                     cdb_out_index, cdb_out_data, dcache_read_addr);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_lw();
        int n;
        push(4'b0010, 5'd1, 32'h100, NL, 32'h0, NL, 32'h4);
        n = 0;
        while (!dcache_read && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (dcache_read !== 1'b1 || dcache_read_addr !== 32'h104) begin
            errors++;
            $display("FAIL lw_req got rd=%b addr=%h exp 1 104",
                     dcache_read, dcache_read_addr);
        end
        repeat (2) tick();
        checks++;
        if (dcache_read !== 1'b1) begin
            errors++;
            $display("FAIL lw_hold got rd=%b exp 1", dcache_read);
        end
        dcache_read_data = 32'hDEADBEEF;
        dcache_read_done = 1'b1;
        tick();
        dcache_read_done = 1'b0;
        checks++;
        if (cdb_out_valid !== 1'b1 || cdb_out_data !== 32'hDEADBEEF ||
            cdb_out_index !== 5'd1 || cdb_out_addr !== 32'h0) begin
            errors++;
            $display("FAIL lw_result got v=%b data=%h idx=%h addr=%h exp 1 deadbeef 01 0",
                     cdb_out_valid, cdb_out_data, cdb_out_index, cdb_out_addr);
        end
        tick();
        checks++;
        if (cdb_out_valid !== 1'b0 || dcache_read !== 1'b0) begin
            errors++;
            $display("FAIL lw_after got v=%b rd=%b exp 0 0",
                     cdb_out_valid, dcache_read);
        end
    endtask

    task automatic test_subword();
        logic [31:0] exp_d [3];
        logic [4:0]  exp_i [3];
        int n;
        exp_d = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011};
        exp_i = '{5'd2, 5'd3, 5'd7};
        push(4'b0000, 5'd2, 32'h103, NL, 32'h0, NL, 32'h0);
        push(4'b0100, 5'd3, 32'h103, NL, 32'h0, NL, 32'h0);
        push(4'b0001, 5'd7, 32'h100, NL, 32'h0, NL, 32'h2);
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!dcache_read && n < 10) begin
                tick();
                n++;
            end
            checks++;
            if (dcache_read !== 1'b1 || dcache_read_addr !== 32'h100) begin
                errors++;
                $display("FAIL sub_req%0d got rd=%b addr=%h exp 1 100",
                         k, dcache_read, dcache_read_addr);
            end
            dcache_read_data = 32'h80112233;
            dcache_read_done = 1'b1;
            tick();
            dcache_read_done = 1'b0;
            checks++;
            if (cdb_out_valid !== 1'b1 || cdb_out_data !== exp_d[k] ||
                cdb_out_index !== exp_i[k]) begin
                errors++;
                $display("FAIL sub_data%0d got v=%b data=%h idx=%h exp 1 %h %h",
                         k, cdb_out_valid, cdb_out_data, cdb_out_index,
                         exp_d[k], exp_i[k]);
            end
        end
        tick();
    endtask

    task automatic test_store_lock();
        rob_stall = 1'b1;
        push(4'b1010, 5'd4, 32'h0, 5'd3, 32'h55, NL, 32'h8);
        cdb_in_index = {5'd3, NL};
        cdb_in_data  = {32'h200, 32'h0};
        tick();
        cdb_in_index = {NL, NL};
        cdb_in_data  = '0;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (cdb_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL st_stall%0d got v=%b exp 0", k, cdb_out_valid);
            end
        end
        rob_stall = 1'b0;
        tick();
        checks++;
        if (cdb_out_valid !== 1'b1 || cdb_out_addr !== 32'h208 ||
            cdb_out_data !== 32'h55 || cdb_out_index !== 5'd4 ||
            cdb_out_exc !== 1'b0) begin
            errors++;
            $display("FAIL st_report got v=%b addr=%h data=%h idx=%h exc=%b exp 1 208 55 04 0",
                     cdb_out_valid, cdb_out_addr, cdb_out_data,
                     cdb_out_index, cdb_out_exc);
        end
        tick();
        checks++;
        if (cdb_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL st_pulse got v=%b exp 0", cdb_out_valid);
        end
    endtask

    task automatic test_bypass();
        cdb_in_index = {5'd7, 5'd7};
        cdb_in_data  = {32'h99, 32'h77};
        push(4'b1010, 5'd5, 32'h300, NL, 32'h0, 5'd7, 32'h0);
        cdb_in_index = {NL, NL};
        cdb_in_data  = '0;
        tick();
        checks++;
        if (cdb_out_valid !== 1'b1 || cdb_out_data !== 32'h77 ||
            cdb_out_addr !== 32'h300 || cdb_out_index !== 5'd5) begin
            errors++;
            $display("FAIL bypass got v=%b data=%h addr=%h idx=%h exp 1 77 300 05",
                     cdb_out_valid, cdb_out_data, cdb_out_addr, cdb_out_index);
        end
        tick();
    endtask

    task automatic test_full();
        logic [4:0] exp_q [8];
        exp_q = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd20, 5'd21};
        rob_stall = 1'b1;
        for (int k = 0; k < 8; k++) begin
            push(4'b1010, 5'(10 + k), 32'h400, NL, 32'(10 + k), NL, 32'h0);
            if (k == 6) begin
                checks++;
                if (buffer_full !== 1'b0) begin
                    errors++;
                    $display("FAIL full_7 got %b exp 0", buffer_full);
                end
            end
        end
        checks++;
        if (buffer_full !== 1'b1) begin
            errors++;
            $display("FAIL full_8 got %b exp 1", buffer_full);
        end
        push(4'b1010, 5'd25, 32'h400, NL, 32'd25, NL, 32'h0);
        checks++;
        if (buffer_full !== 1'b1 || cdb_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drop got full=%b v=%b exp 1 0",
                     buffer_full, cdb_out_valid);
        end
        rob_stall = 1'b0;
        push(4'b1010, 5'd26, 32'h400, NL, 32'd26, NL, 32'h0);
        rob_stall = 1'b1;
        checks++;
        if (cdb_out_valid !== 1'b1 || cdb_out_index !== 5'd10 ||
            buffer_full !== 1'b0) begin
            errors++;
            $display("FAIL full_poprefuse got v=%b idx=%h full=%b exp 1 0a 0",
                     cdb_out_valid, cdb_out_index, buffer_full);
        end
        rob_stall = 1'b0;
        push(4'b1010, 5'd20, 32'h400, NL, 32'd20, NL, 32'h0);
        rob_stall = 1'b1;
        checks++;
        if (cdb_out_valid !== 1'b1 || cdb_out_index !== 5'd11 ||
            buffer_full !== 1'b0) begin
            errors++;
            $display("FAIL full_pushpop got v=%b idx=%h full=%b exp 1 0b 0",
                     cdb_out_valid, cdb_out_index, buffer_full);
        end
        push(4'b1010, 5'd21, 32'h400, NL, 32'd21, NL, 32'h0);
        checks++;
        if (buffer_full !== 1'b1) begin
            errors++;
            $display("FAIL full_refill got %b exp 1", buffer_full);
        end
        rob_stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if (cdb_out_valid !== 1'b1 || cdb_out_index !== exp_q[k] ||
                cdb_out_data !== 32'(exp_q[k])) begin
                errors++;
                $display("FAIL full_drain%0d got v=%b idx=%h data=%h exp 1 %h %h",
                         k, cdb_out_valid, cdb_out_index, cdb_out_data,
                         exp_q[k], 32'(exp_q[k]));
            end
        end
        tick();
        checks++;
        if (cdb_out_valid !== 1'b0 || buffer_full !== 1'b0) begin
            errors++;
            $display("FAIL full_empty got v=%b full=%b exp 0 0",
                     cdb_out_valid, buffer_full);
        end
    endtask

    task automatic test_flush();
        int n;
        push(4'b0010, 5'd6, 32'h400, NL, 32'h0, NL, 32'h0);
        n = 0;
        while (!dcache_read && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (dcache_read !== 1'b1) begin
            errors++;
            $display("FAIL flush_req got rd=%b exp 1", dcache_read);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (dcache_read !== 1'b0 || buffer_full !== 1'b0 ||
            cdb_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_kill got rd=%b full=%b v=%b exp 0 0 0",
                     dcache_read, buffer_full, cdb_out_valid);
        end
        dcache_read_data = 32'h12345678;
        dcache_read_done = 1'b1;
        tick();
        dcache_read_done = 1'b0;
        tick();
        checks++;
        if (cdb_out_valid !== 1'b0 || dcache_read !== 1'b0) begin
            errors++;
            $display("FAIL flush_late got v=%b rd=%b exp 0 0",
                     cdb_out_valid, dcache_read);
        end
        push(4'b1010, 5'd8, 32'h500, NL, 32'hAA, NL, 32'h0);
        tick();
        checks++;
        if (cdb_out_valid !== 1'b1 || cdb_out_index !== 5'd8) begin
            errors++;
            $display("FAIL flush_empty got v=%b idx=%h exp 1 08",
                     cdb_out_valid, cdb_out_index);
        end
        push(4'b1010, 5'd9, 32'h500, NL, 32'hBB, NL, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (cdb_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_pop got v=%b exp 0", cdb_out_valid);
        end
        tick();
        checks++;
        if (cdb_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_gone got v=%b exp 0", cdb_out_valid);
        end
    endtask

    task automatic test_misalign();
`ifdef LSQ_MISALIGN_TRAP_EN
        push(4'b0010, 5'd12, 32'h102, NL, 32'h0, NL, 32'h0);
        tick();
        checks++;
        if (cdb_out_valid !== 1'b1 || cdb_out_exc !== 1'b1 ||
            cdb_out_data !== 32'h0 || cdb_out_index !== 5'd12 ||
            dcache_read !== 1'b0) begin
            errors++;
            $display("FAIL mis_trap got v=%b exc=%b data=%h idx=%h rd=%b exp 1 1 0 0c 0",
                     cdb_out_valid, cdb_out_exc, cdb_out_data,
                     cdb_out_index, dcache_read);
        end
        tick();
`else
        int n;
        push(4'b0010, 5'd12, 32'h102, NL, 32'h0, NL, 32'h0);
        n = 0;
        while (!dcache_read && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (dcache_read !== 1'b1 || dcache_read_addr !== 32'h100) begin
            errors++;
            $display("FAIL mis_addr got rd=%b addr=%h exp 1 100",
                     dcache_read, dcache_read_addr);
        end
        dcache_read_data = 32'h11223344;
        dcache_read_done = 1'b1;
        tick();
        dcache_read_done = 1'b0;
        checks++;
        if (cdb_out_valid !== 1'b1 || cdb_out_exc !== 1'b0 ||
            cdb_out_data !== 32'h11223344) begin
            errors++;
            $display("FAIL mis_noexc got v=%b exc=%b data=%h exp 1 0 11223344",
                     cdb_out_valid, cdb_out_exc, cdb_out_data);
        end
        tick();
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        flush            = 1'b0;
        lsm_write        = 1'b0;
        lsm_op           = 4'h0;
        lsm_rob          = 5'h0;
        lsm_base         = 32'h0;
        lsm_base_lock    = NL;
        lsm_sdata        = 32'h0;
        lsm_sdata_lock   = NL;
        lsm_offset       = 32'h0;
        cdb_in_index     = {NL, NL};
        cdb_in_data      = '0;
        rob_stall        = 1'b0;
        dcache_read_done = 1'b0;
        dcache_read_data = 32'h0;
        test_reset();
        test_lw();
        test_subword();
        test_store_lock();
        test_bypass();
        test_full();
        test_flush();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
